// File: rtl/z80fi_block_ld_checker_if.sv
// Retirement trace bus for the block-load checker: one record per retired
// instruction, driven by the trace source (master) and consumed by the
// checker (slave).
interface z80fi_block_ld_checker_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  logic              z80fi_valid;
  logic [15:0]       z80fi_insn;
  logic [2:0]        z80fi_insn_len;
  logic [ADDR_W-1:0] pc_rdata;
  logic [ADDR_W-1:0] pc_wdata;
  logic [ADDR_W-1:0] hl_rdata;
  logic [ADDR_W-1:0] hl_wdata;
  logic [ADDR_W-1:0] de_rdata;
  logic [ADDR_W-1:0] de_wdata;
  logic [CNT_W-1:0]  bc_rdata;
  logic [CNT_W-1:0]  bc_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_rdata;
  logic [7:0]        mem_wdata;
  logic              irq_taken;

  modport master (
    output z80fi_valid, z80fi_insn, z80fi_insn_len,
    output pc_rdata, pc_wdata, hl_rdata, hl_wdata, de_rdata, de_wdata,
    output bc_rdata, bc_wdata, mem_raddr, mem_waddr, mem_rdata, mem_wdata,
    output irq_taken
  );

  modport slave (
    input z80fi_valid, z80fi_insn, z80fi_insn_len,
    input pc_rdata, pc_wdata, hl_rdata, hl_wdata, de_rdata, de_wdata,
    input bc_rdata, bc_wdata, mem_raddr, mem_waddr, mem_rdata, mem_wdata,
    input irq_taken
  );
endinterface

// File: rtl/z80fi_block_ld_checker.sv
// Formal-interface style checker for the Z80 block-load group
// (LDI/LDD/LDIR/LDDR). Each recognised retirement is checked against the
// architectural rules and the result is reported one cycle later. Repeat
// forms are tracked across iterations so that a broken or runaway LDIR/LDDR
// sequence is flagged.
module z80fi_block_ld_checker #(
  parameter  int ADDR_W    = 16,
  parameter  int CNT_W     = 16,
  parameter  int MAX_ITER  = 65536,
  parameter  int REPEAT_EN = 1,
  localparam int ITER_W    = $clog2(MAX_ITER + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  z80fi_block_ld_checker_if.slave fi,
  output logic                   chk_valid,
  output logic                   chk_fail,
  output logic [3:0]             fail_code,
  output logic                   busy,
  output logic [ITER_W-1:0]      iter_count
);

  typedef enum logic {IDLE, REPEAT} state_t;

  localparam logic [3:0] C_NONE  = 4'd0;
  localparam logic [3:0] C_RADDR = 4'd1;
  localparam logic [3:0] C_WADDR = 4'd2;
  localparam logic [3:0] C_DATA  = 4'd3;
  localparam logic [3:0] C_HL    = 4'd4;
  localparam logic [3:0] C_DE    = 4'd5;
  localparam logic [3:0] C_BC    = 4'd6;
  localparam logic [3:0] C_PC    = 4'd7;
  localparam logic [3:0] C_SEQ   = 4'd8;
  localparam logic [3:0] C_WDOG  = 4'd9;

  state_t            state, nxt_state;
  logic [7:0]        op;
  logic              is_ld, is_rep, recog, dec, cont;
  logic [ADDR_W-1:0] hl_exp, de_exp, pc_exp;
  logic [CNT_W-1:0]  bc_exp;
  logic [3:0]        chk_code, nxt_code;
  logic              seq_ok, irq_exit;
  logic              evt, latch;
  logic [ITER_W-1:0] nxt_iter;
  int                iter_inc;

  // Sequence context captured from the last passing, still-repeating iteration.
  logic [7:0]        lat_op;
  logic [ADDR_W-1:0] lat_pc, lat_hl, lat_de;
  logic [CNT_W-1:0]  lat_bc;

  // Decode and per-retirement architectural checks, lowest code wins.
  always_comb begin
    op     = fi.z80fi_insn[7:0];
    is_ld  = (op == 8'hA0) || (op == 8'hA8);
    is_rep = (REPEAT_EN != 0) && ((op == 8'hB0) || (op == 8'hB8));
    recog  = fi.z80fi_valid && (fi.z80fi_insn_len == 3'd2) &&
             (fi.z80fi_insn[15:8] == 8'hED) && (is_ld || is_rep);
    dec    = op[3];
    cont   = is_rep && (fi.bc_wdata != '0);
    hl_exp = dec ? fi.hl_rdata - ADDR_W'(1) : fi.hl_rdata + ADDR_W'(1);
    de_exp = dec ? fi.de_rdata - ADDR_W'(1) : fi.de_rdata + ADDR_W'(1);
    bc_exp = fi.bc_rdata - CNT_W'(1);
    // A repeat that still has work to do re-executes from the same PC.
    pc_exp = cont ? fi.pc_rdata : fi.pc_rdata + ADDR_W'(2);
    if      (fi.mem_raddr != fi.hl_rdata) chk_code = C_RADDR;
    else if (fi.mem_waddr != fi.de_rdata) chk_code = C_WADDR;
    else if (fi.mem_wdata != fi.mem_rdata) chk_code = C_DATA;
    else if (fi.hl_wdata != hl_exp)       chk_code = C_HL;
    else if (fi.de_wdata != de_exp)       chk_code = C_DE;
    else if (fi.bc_wdata != bc_exp)       chk_code = C_BC;
    else if (fi.pc_wdata != pc_exp)       chk_code = C_PC;
    else                                  chk_code = C_NONE;
  end

  // A continuing iteration must pick up exactly where the previous one left off.
  assign seq_ok   = (op == lat_op) && (fi.pc_rdata == lat_pc) &&
                    (fi.hl_rdata == lat_hl) && (fi.de_rdata == lat_de) &&
                    (fi.bc_rdata == lat_bc);
  // An interrupt taken between iterations returns to the repeat opcode later.
  assign irq_exit = fi.irq_taken && (fi.pc_wdata == lat_pc);

  // FSM next state, result code and context-latch control.
  always_comb begin
    nxt_state = state;
    nxt_code  = C_NONE;
    nxt_iter  = iter_count;
    evt       = 1'b0;
    latch     = 1'b0;
    iter_inc  = int'(iter_count) + 1;
    case (state)
      IDLE: begin
        if (recog) begin
          evt      = 1'b1;
          nxt_code = chk_code;
          if (chk_code == C_NONE && cont) begin
            if (1 >= MAX_ITER) begin
              nxt_code = C_WDOG;
            end else begin
              nxt_state = REPEAT;
              latch     = 1'b1;
              nxt_iter  = ITER_W'(1);
            end
          end
        end
      end
      REPEAT: begin
        if (fi.z80fi_valid) begin
          evt       = 1'b1;
          nxt_state = IDLE;
          nxt_iter  = '0;
          if (irq_exit)                nxt_code = C_NONE;
          else if (!recog)             nxt_code = C_SEQ;
          else if (chk_code != C_NONE) nxt_code = chk_code;
          else if (!seq_ok)            nxt_code = C_SEQ;
          else if (cont) begin
            if (iter_inc >= MAX_ITER) begin
              nxt_code = C_WDOG;
            end else begin
              nxt_state = REPEAT;
              latch     = 1'b1;
              nxt_iter  = ITER_W'(iter_inc);
            end
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // State, result pulse, iteration counter and sequence context registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      chk_valid  <= 1'b0;
      fail_code  <= C_NONE;
      iter_count <= '0;
      lat_op     <= '0;
      lat_pc     <= '0;
      lat_hl     <= '0;
      lat_de     <= '0;
      lat_bc     <= '0;
    end else begin
      state      <= nxt_state;
      chk_valid  <= evt;
      fail_code  <= evt ? nxt_code : C_NONE;
      iter_count <= nxt_iter;
      if (latch) begin
        lat_op <= op;
        lat_pc <= fi.pc_rdata;
        lat_hl <= fi.hl_wdata;
        lat_de <= fi.de_wdata;
        lat_bc <= fi.bc_wdata;
      end
    end
  end

  assign chk_fail = (fail_code != C_NONE);
  assign busy     = (state == REPEAT);

endmodule

// File: doc/z80fi_block_ld_checker.md
Z80FI_BLOCK_LD_CHECKER -- requirements
Module: z80fi_block_ld_checker

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, width of HL/DE/PC and memory address.
REQ-002 SHALL have parameter CNT_W, default 16, width of BC counter.
REQ-003 SHALL have parameter MAX_ITER, default 65536, watchdog limit on consecutive repeat iterations.
REQ-004 SHALL have parameter REPEAT_EN, default 1; 0 disables LDIR/LDDR, which are then ignored.
REQ-005 Ports: clk in 1 clock; reset in 1 synchronous active-high reset; one clock, reset is synchronous and active-high.
REQ-006 Ports: z80fi_valid in 1 instruction retired; z80fi_insn in 16 opcode pair {ED, op}; z80fi_insn_len in 3 bytes.
REQ-007 Ports: pc_rdata/pc_wdata in ADDR_W each, PC before/after retirement.
REQ-008 Ports: hl_rdata, de_rdata, hl_wdata, de_wdata in ADDR_W; bc_rdata, bc_wdata in CNT_W; pre/post values.
REQ-009 Ports: mem_raddr, mem_waddr in ADDR_W; mem_rdata, mem_wdata in 8; irq_taken in 1 interrupt accepted at this retirement.
REQ-010 Ports: chk_valid out 1; chk_fail out 1; fail_code out 4; busy out 1 repeat in progress; iter_count out clog2(MAX_ITER+1).

Function
REQ-011 SHALL recognise, when z80fi_valid and insn_len==2: ED A0 LDI, ED A8 LDD, ED B0 LDIR, ED B8 LDDR; all else ignored.
REQ-012 SHALL check: mem_raddr==hl_rdata; mem_waddr==de_rdata; mem_wdata==mem_rdata.
REQ-013 SHALL check HL/DE post = pre+1 (LDI/LDIR) or pre-1 (LDD/LDDR), modulo 2^ADDR_W (FFFF+1->0000, 0000-1->FFFF).
REQ-014 SHALL check bc_wdata = bc_rdata-1 modulo 2^CNT_W; BC 0000 pre yields FFFF and repeat continues.
REQ-015 SHALL check PC: LDI/LDD or repeat with bc_wdata==0 -> pc_wdata=pc_rdata+2; repeat with bc_wdata!=0 -> pc_wdata=pc_rdata.
REQ-016 Latency: SHALL register results; chk_valid high exactly one cycle after each recognised retirement, one-cycle pulse.
REQ-017 fail_code SHALL be lowest-numbered failing check: 0 none, 1 raddr, 2 waddr, 3 data, 4 HL, 5 DE, 6 BC, 7 PC, 8 sequence break, 9 watchdog; chk_fail = (fail_code!=0).
REQ-018 FSM SHALL have states IDLE and REPEAT; busy = (state==REPEAT).
REQ-019 IDLE->REPEAT on passing LDIR/LDDR with bc_wdata!=0; SHALL latch opcode, PC, expected HL/DE/BC (post values); iter_count:=1.
REQ-020 In REPEAT, next valid retirement SHALL have same opcode, pc_rdata equal latched PC, and HL/DE/BC pre equal latched; else code 8, state->IDLE.
REQ-021 In REPEAT, irq_taken with pc_wdata==latched PC SHALL be legal: state->IDLE, no failure, chk_valid pulses with code 0.
REQ-022 REPEAT iteration passing with bc_wdata!=0 SHALL relatch and increment iter_count; with bc_wdata==0 SHALL go IDLE, iter_count:=0.
REQ-023 iter_count reaching MAX_ITER while still repeating SHALL report code 9 and go IDLE.
REQ-024 Any failure SHALL return FSM to IDLE; next retirement is evaluated fresh.
REQ-025 Non-recognised retirement in REPEAT SHALL report code 8 (chk_valid pulses) unless irq_taken per REQ-021.
REQ-026 REPEAT_EN=0: ED B0/B8 not recognised, FSM never leaves IDLE.
REQ-027 z80fi_valid low SHALL hold state, counters and latched values.

Reset
REQ-028 reset SHALL dominate same-cycle z80fi_valid; clears state to IDLE, chk_valid/chk_fail/busy 0, fail_code 0, iter_count 0, latches 0.
REQ-029 reset mid-REPEAT SHALL abandon the sequence with no chk_valid pulse; first retirement after reset evaluated as from IDLE.

Verification
REQ-030 LDI, HL=1000 DE=2000 BC=0003 PC=0100, post HL=1001 DE=2001 BC=0002 PC=0102 -> chk_valid next cycle, code 0.
REQ-031 LDIR BC=0002: iteration 1 PC stays 0100, BC 0001 -> busy=1 iter_count=1; iteration 2 BC 0000 PC 0102 -> code 0, busy=0.
REQ-032 LDDR HL=0000 DE=0000 BC=0001 -> post HL=FFFF DE=FFFF BC=0000 PC+2 -> code 0; with HL post 0001 -> code 4.
REQ-033 In REPEAT, retire NOP (insn_len 1) -> code 8, busy=0; in REPEAT, irq_taken with PC=latched -> code 0, busy=0.
REQ-034 MAX_ITER=4, LDIR BC=0010 valid iterations -> fourth iteration code 9, busy=0.
REQ-035 reset asserted during REPEAT with z80fi_valid high -> no chk_valid, busy=0, iter_count=0 next cycle.
